// File: rtl/pio_bus_arbiter.sv
// Round-robin arbiter sharing one zero-wait-state PIO slave between two Avalon-MM requesters.
// Define PIO_ARB_LOCK_EN to add per-master lock inputs for atomic read-modify-write sequences.
module pio_bus_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_chipselect,
    input  logic              m0_write_n,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_chipselect,
    input  logic              m1_write_n,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,
`ifdef PIO_ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    output logic [ADDR_W-1:0] s_address,
    output logic              s_chipselect,
    output logic              s_write_n,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   s_address_q, s_address_d;
    logic                s_chipselect_q, s_chipselect_d;
    logic                s_write_n_q, s_write_n_d;
    logic [DATA_W-1:0]   s_writedata_q, s_writedata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                req0, req1;

`ifdef PIO_ARB_LOCK_EN
    logic lock_q, lock_d;
    logic owner_valid_q, owner_valid_d;
    logic owner_q, owner_d;

    // While a master owns the bus, the other one's request is masked out.
    assign req0 = m0_chipselect && !(owner_valid_q && owner_q);
    assign req1 = m1_chipselect && !(owner_valid_q && !owner_q);
`else
    assign req0 = m0_chipselect;
    assign req1 = m1_chipselect;
`endif

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        s_address_d    = s_address_q;
        s_chipselect_d = s_chipselect_q;
        s_write_n_d    = s_write_n_q;
        s_writedata_d  = s_writedata_q;
        rdata_d        = rdata_q;
`ifdef PIO_ARB_LOCK_EN
        lock_d         = lock_q;
        owner_valid_d  = owner_valid_q;
        owner_d        = owner_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    grant_d        = (req0 && req1) ? !last_grant_q : req1;
                    s_address_d    = grant_d ? m1_address   : m0_address;
                    s_write_n_d    = grant_d ? m1_write_n   : m0_write_n;
                    s_writedata_d  = grant_d ? m1_writedata : m0_writedata;
                    s_chipselect_d = 1'b1;
`ifdef PIO_ARB_LOCK_EN
                    lock_d         = grant_d ? m1_lock : m0_lock;
`endif
                    state_d        = StIssue;
                end
            end
            StIssue: begin
                rdata_d        = s_readdata;
                s_chipselect_d = 1'b0;
                s_write_n_d    = 1'b1;
                last_grant_d   = grant_q;
`ifdef PIO_ARB_LOCK_EN
                // Only the owner can be granted while owned, so its lock bit decides.
                owner_valid_d  = lock_q;
                owner_d        = grant_q;
`endif
                state_d        = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            grant_q        <= 1'b0;
            last_grant_q   <= 1'b1;
            s_address_q    <= '0;
            s_chipselect_q <= 1'b0;
            s_write_n_q    <= 1'b1;
            s_writedata_q  <= '0;
            rdata_q        <= '0;
`ifdef PIO_ARB_LOCK_EN
            lock_q         <= 1'b0;
            owner_valid_q  <= 1'b0;
            owner_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            s_address_q    <= s_address_d;
            s_chipselect_q <= s_chipselect_d;
            s_write_n_q    <= s_write_n_d;
            s_writedata_q  <= s_writedata_d;
            rdata_q        <= rdata_d;
`ifdef PIO_ARB_LOCK_EN
            lock_q         <= lock_d;
            owner_valid_q  <= owner_valid_d;
            owner_q        <= owner_d;
`endif
        end
    end

    assign s_address    = s_address_q;
    assign s_chipselect = s_chipselect_q;
    assign s_write_n    = s_write_n_q;
    assign s_writedata  = s_writedata_q;

    assign m0_waitrequest = !((state_q == StResp) && !grant_q);
    assign m1_waitrequest = !((state_q == StResp) && grant_q);
    assign m0_readdata    = ((state_q == StResp) && !grant_q) ? rdata_q : '0;
    assign m1_readdata    = ((state_q == StResp) && grant_q) ? rdata_q : '0;

endmodule

// File: tb/tb_pio_bus_arbiter.sv
// Directed bench for pio_bus_arbiter with a behavioural PIO slave (data/set/clear registers).
// Lock scenario runs only when PIO_ARB_LOCK_EN is defined.
module tb_pio_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  m0_address = '0, m1_address = '0;
    logic        m0_chipselect = 1'b0, m1_chipselect = 1'b0;
    logic        m0_write_n = 1'b1, m1_write_n = 1'b1;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest;
`ifdef PIO_ARB_LOCK_EN
    logic        m0_lock = 1'b0, m1_lock = 1'b0;
`endif
    logic [2:0]  s_address;
    logic        s_chipselect, s_write_n;
    logic [31:0] s_writedata, s_readdata;
    logic [31:0] pio = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pio_bus_arbiter #(.DATA_W(32), .ADDR_W(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_chipselect(m0_chipselect), .m0_write_n(m0_write_n),
        .m0_writedata(m0_writedata), .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_chipselect(m1_chipselect), .m1_write_n(m1_write_n),
        .m1_writedata(m1_writedata), .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
`ifdef PIO_ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
        .s_writedata(s_writedata), .s_readdata(s_readdata)
    );

    // PIO slave: data at 0, bit-set at 4, bit-clear at 5; readdata is combinational.
    assign s_readdata = (s_address == 3'd0) ? pio : 32'h0;
    always @(posedge clk) begin
        if (s_chipselect && !s_write_n) begin
            case (s_address)
                3'd0:    pio <= s_writedata;
                3'd4:    pio <= pio | s_writedata;
                3'd5:    pio <= pio & ~s_writedata;
                default: ;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        total++; if (s_chipselect !== 1'b0) begin bad++; $display("FAIL rst_cs got=%0b want=0", s_chipselect); end
        total++; if (s_write_n !== 1'b1) begin bad++; $display("FAIL rst_wn got=%0b want=1", s_write_n); end
        total++; if (s_address !== 3'd0 || s_writedata !== 32'h0) begin
            bad++; $display("FAIL rst_addr_wd got=%0h/%0h want=0/0", s_address, s_writedata); end
        total++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
            bad++; $display("FAIL rst_wait got=%0b%0b want=11", m0_waitrequest, m1_waitrequest); end
        total++; if (m0_readdata !== 32'h0 || m1_readdata !== 32'h0) begin
            bad++; $display("FAIL rst_rdata got=%0h/%0h want=0/0", m0_readdata, m1_readdata); end
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (s_chipselect !== 1'b0 || m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
                bad++; $display("FAIL idle_quiet cyc=%0d got cs=%0b w=%0b%0b want cs=0 w=11",
                                i, s_chipselect, m0_waitrequest, m1_waitrequest); end
        end
    endtask

    task automatic test_write();
        m0_chipselect = 1'b1; m0_write_n = 1'b0; m0_address = 3'd0; m0_writedata = 32'h0000_00A5;
        tick();
        total++; if (s_chipselect !== 1'b1 || s_address !== 3'd0 || s_write_n !== 1'b0) begin
            bad++; $display("FAIL wr_strobe got cs=%0b a=%0d wn=%0b want 1/0/0", s_chipselect, s_address, s_write_n); end
        total++; if (s_writedata !== 32'hA5) begin bad++; $display("FAIL wr_data got=%0h want=a5", s_writedata); end
        total++; if (m0_waitrequest !== 1'b1) begin bad++; $display("FAIL wr_wait_n1 got=%0b want=1", m0_waitrequest); end
        tick();
        total++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
            bad++; $display("FAIL wr_done got=%0b%0b want=01", m0_waitrequest, m1_waitrequest); end
        m0_chipselect = 1'b0; m0_write_n = 1'b1;
        tick();
        total++; if (pio !== 32'hA5) begin bad++; $display("FAIL wr_slave got=%0h want=a5", pio); end
    endtask

    task automatic test_read();
        m1_chipselect = 1'b1; m1_write_n = 1'b1; m1_address = 3'd0;
        tick();
        total++; if (s_chipselect !== 1'b1 || s_write_n !== 1'b1) begin
            bad++; $display("FAIL rd_strobe got cs=%0b wn=%0b want 1/1", s_chipselect, s_write_n); end
        tick();
        total++; if (m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1) begin
            bad++; $display("FAIL rd_wait got=%0b%0b want=10", m0_waitrequest, m1_waitrequest); end
        total++; if (m1_readdata !== 32'hA5) begin bad++; $display("FAIL rd_m1data got=%0h want=a5", m1_readdata); end
        total++; if (m0_readdata !== 32'h0) begin bad++; $display("FAIL rd_m0data got=%0h want=0", m0_readdata); end
        m1_chipselect = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic exp_cs, exp_w0, exp_w1;
        m0_chipselect = 1'b1; m0_write_n = 1'b0; m0_address = 3'd4; m0_writedata = 32'h0F;
        m1_chipselect = 1'b1; m1_write_n = 1'b0; m1_address = 3'd5; m1_writedata = 32'h03;
        for (int i = 1; i <= 11; i++) begin
            tick();
            exp_cs = (i % 3 == 1);
            exp_w0 = !(i == 2 || i == 8);
            exp_w1 = !(i == 5 || i == 11);
            total++; if (s_chipselect !== exp_cs || m0_waitrequest !== exp_w0 || m1_waitrequest !== exp_w1) begin
                bad++; $display("FAIL rr cyc=%0d got cs=%0b w=%0b%0b want cs=%0b w=%0b%0b", i,
                                s_chipselect, m0_waitrequest, m1_waitrequest, exp_cs, exp_w0, exp_w1); end
        end
        m0_chipselect = 1'b0; m1_chipselect = 1'b0; m0_write_n = 1'b1; m1_write_n = 1'b1;
        tick();
        total++; if (pio !== 32'hAC) begin bad++; $display("FAIL rr_slave got=%0h want=ac", pio); end
    endtask

    task automatic test_reset_mid();
        m0_chipselect = 1'b1; m0_write_n = 1'b1; m0_address = 3'd0;
        tick();
        tick();
        total++; if (m0_waitrequest !== 1'b0 || m0_readdata !== 32'hAC) begin
            bad++; $display("FAIL mid_rd got w=%0b d=%0h want 0/ac", m0_waitrequest, m0_readdata); end
        tick();
        tick();
        total++; if (s_chipselect !== 1'b1) begin bad++; $display("FAIL mid_issue got=%0b want=1", s_chipselect); end
        reset_n = 1'b0;
        #1;
        total++; if (s_chipselect !== 1'b0) begin bad++; $display("FAIL mid_async_cs got=%0b want=0", s_chipselect); end
        m0_chipselect = 1'b0;
        tick();
        reset_n = 1'b1;
        total++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || s_chipselect !== 1'b0) begin
            bad++; $display("FAIL mid_after got w=%0b%0b cs=%0b want 11/0", m0_waitrequest, m1_waitrequest, s_chipselect); end
        m0_chipselect = 1'b1; m0_write_n = 1'b1; m0_address = 3'd0;
        m1_chipselect = 1'b1; m1_write_n = 1'b1; m1_address = 3'd0;
        tick();
        tick();
        total++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
            bad++; $display("FAIL mid_tie got=%0b%0b want=01", m0_waitrequest, m1_waitrequest); end
        m0_chipselect = 1'b0; m1_chipselect = 1'b0;
        tick();
    endtask

`ifdef PIO_ARB_LOCK_EN
    task automatic test_lock();
        m0_chipselect = 1'b1; m0_write_n = 1'b1; m0_address = 3'd0; m0_lock = 1'b1;
        tick();
        total++; if (s_chipselect !== 1'b1 || s_write_n !== 1'b1 || s_address !== 3'd0) begin
            bad++; $display("FAIL lk_rd got cs=%0b wn=%0b a=%0d want 1/1/0", s_chipselect, s_write_n, s_address); end
        m1_chipselect = 1'b1; m1_write_n = 1'b0; m1_address = 3'd5; m1_writedata = 32'h01;
        tick();
        total++; if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL lk_rd_done got=%0b want=0", m0_waitrequest); end
        m0_write_n = 1'b0; m0_writedata = 32'h55; m0_lock = 1'b0;
        tick();
        tick();
        total++; if (s_chipselect !== 1'b1 || s_address !== 3'd0 || s_write_n !== 1'b0 || s_writedata !== 32'h55) begin
            bad++; $display("FAIL lk_wr got cs=%0b a=%0d wn=%0b d=%0h want 1/0/0/55",
                            s_chipselect, s_address, s_write_n, s_writedata); end
        tick();
        total++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
            bad++; $display("FAIL lk_wr_done got=%0b%0b want=01", m0_waitrequest, m1_waitrequest); end
        m0_chipselect = 1'b0; m0_write_n = 1'b1;
        tick();
        tick();
        total++; if (s_chipselect !== 1'b1 || s_address !== 3'd5) begin
            bad++; $display("FAIL lk_m1 got cs=%0b a=%0d want 1/5", s_chipselect, s_address); end
        tick();
        total++; if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL lk_m1_done got=%0b want=0", m1_waitrequest); end
        m1_chipselect = 1'b0; m1_write_n = 1'b1;
        tick();
        total++; if (pio !== 32'h54) begin bad++; $display("FAIL lk_slave got=%0h want=54", pio); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_reset_mid();
`ifdef PIO_ARB_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pio_bus_arbiter.md
Name: pio_bus_arbiter

Overview:
- Two-requester Avalon-MM arbiter that shares one zero-wait-state PIO slave (32-bit data, word address 0 = data, 4 = bit-set, 5 = bit-clear).
- Typical pairing: Nios II data master on port m0, hardware timer/sequencer master on port m1.
- Serialises accesses with round-robin grant and returns read data through a holding register.
- Uses waitrequest to stall the losing and in-flight requesters.

Parameters:
- DATA_W, 32, data width of all writedata/readdata buses.
- ADDR_W, 3, word-address width passed through to the slave.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- m0_address  in  ADDR_W  requester 0 word address
- m0_chipselect  in  1  requester 0 request
- m0_write_n  in  1  requester 0 write when 0, read when 1
- m0_writedata  in  DATA_W  requester 0 write data
- m0_readdata  out  DATA_W  requester 0 read data
- m0_waitrequest  out  1  requester 0 stall
- m1_address, m1_chipselect, m1_write_n, m1_writedata, m1_readdata, m1_waitrequest: same widths, directions and meaning as the m0_* ports, for requester 1
- s_address  out  ADDR_W  to PIO slave, registered
- s_chipselect  out  1  to PIO slave, registered
- s_write_n  out  1  to PIO slave, registered
- s_writedata  out  DATA_W  to PIO slave, registered
- s_readdata  in  DATA_W  from PIO slave, combinational, valid in the same cycle

Behaviour:
- Reset values:
  - FSM = IDLE.
  - s_chipselect = 0, s_write_n = 1, s_address = 0, s_writedata = 0.
  - rdata_q = 0; m0_readdata and m1_readdata = 0.
  - m0_waitrequest and m1_waitrequest = 1.
  - last_grant = 1, so m0 wins the first tie.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - A request is mX_chipselect = 1.
  - If any request: pick the winner and register it in grant.
    - Single requester wins.
    - Both requesting: winner is the master that is not last_grant.
  - Latch the winner's address, write_n and writedata into the s_* registers; set s_chipselect = 1.
  - Next state ISSUE.
- ISSUE (exactly one cycle):
  - Slave sees the strobe.
  - At the clock edge: capture s_readdata into rdata_q (captured for reads and writes alike); clear s_chipselect; set s_write_n = 1; last_grant = grant.
  - Next state RESP.
- RESP (one cycle):
  - mX_waitrequest = 0 for the granted master only.
  - mX_readdata = rdata_q for the granted master; the other master's readdata = 0.
  - Next state IDLE.
- Waitrequest is 1 in every other state/master combination, so a requester that raises chipselect is always stalled at least until RESP.
- Latency: request in cycle N (FSM in IDLE) -> s_chipselect = 1 in N+1 -> waitrequest = 0 in N+2.
  - Earliest next grant decision is N+3.
  - Peak throughput: one access per 3 cycles.
- Requester rule: hold all mX_* inputs stable while waitrequest = 1.
  - The arbiter uses only the values latched in IDLE.
  - A requester dropping chipselect after grant still completes; its slave access is not cancelled.
- Fairness: with both masters requesting continuously, grants alternate m0, m1, m0, …
  - Neither waits more than one other transaction.
- Reset mid-transaction: FSM returns to IDLE and s_chipselect drops immediately (asynchronous). No partial second strobe is issued.
- No combinational path from any mX_* input to any output.

Optional Feature:
- Macro PIO_ARB_LOCK_EN.
- Enabled:
  - Adds inputs m0_lock and m1_lock, 1 bit each, sampled in IDLE together with the request.
  - If the granted master had lock = 1, the arbiter sets an internal owner flag. Following IDLE decisions then grant only that master; the other master stalls with waitrequest = 1.
  - The flag clears when the owner completes a transaction with lock = 0.
  - Purpose: atomic read-modify-write of the data register (address 0).
- Disabled: no lock ports; pure round-robin as above.

Test Plan:
- Reset release, no requests -> s_chipselect = 0 forever; both waitrequest = 1; both readdata = 0.
- m0 writes 0x0000_00A5 to addr 0 at cycle N -> s_chipselect = 1, s_address = 0, s_write_n = 0, s_writedata = 0xA5 at N+1; m0_waitrequest = 0 at N+2; m1_waitrequest stays 1.
- Slave holds 0xA5; m1 reads addr 0 -> m1_readdata = 0x0000_00A5 in its waitrequest = 0 cycle; m0_readdata = 0.
- m0 and m1 both hold requests continuously (m0 set-bits 0x0F at addr 4, m1 clear-bits 0x03 at addr 5) -> grant order m0, m1, m0, m1; s_chipselect pulses every 3rd cycle.
- reset_n asserted during ISSUE -> s_chipselect = 0 in the same cycle; after release both waitrequest = 1; m0 wins the next tie.
- With PIO_ARB_LOCK_EN: m0 does a locked read of addr 0 while m1 is requesting, then an unlocked write of 0x55 -> m1 is not granted until after m0's write completes; the slave sees m0 read, m0 write, then m1.
